// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit multiply/divide unit, one bit per cycle
module multdiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  count;
  logic [63:0] acc;        // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] operand;    // |A| as multiplicand, or |B| as divisor
  logic        is_div;
  logic        neg;
  logic        div_zero;
  logic        div_ovf;

  logic        start;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot;
  logic        mul_ovf;

  assign start = ctrl_MULT | ctrl_DIV;
  assign busy  = (state != IDLE);

  assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  // Shift-add step: add the multiplicand when the current multiplier bit is set, then shift right
  assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
  assign mul_next = {mul_sum, acc[31:1]};

  // Restoring step: shift in the next dividend bit and keep the subtraction only if it stays non-negative
  assign rem_shift = acc[63:31];
  assign trial     = rem_shift - {1'b0, operand};
  assign div_next  = trial[32] ? {rem_shift[31:0], acc[30:0], 1'b0}
                               : {trial[31:0], acc[30:0], 1'b1};

  assign prod    = neg ? (~acc + 64'd1) : acc;
  assign quot    = neg ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign mul_ovf = ~((&prod[63:31]) | ~(|prod[63:31]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MULT : DIV;
    end else begin
      case (state)
        MULT, DIV: if (count == 6'(ITER - 1)) state_nxt = DONE;
        DONE:      state_nxt = IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count          <= 6'd0;
      acc            <= 64'd0;
      operand        <= 32'd0;
      is_div         <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A new request always wins, which also aborts whatever was in flight
        count    <= 6'd0;
        is_div   <= ~ctrl_MULT;
        neg      <= data_operandA[31] ^ data_operandB[31];
        div_zero <= ~ctrl_MULT & (data_operandB == 32'd0);
        div_ovf  <= ~ctrl_MULT & (data_operandA == 32'h8000_0000) & (data_operandB == 32'hFFFF_FFFF);
        if (ctrl_MULT) begin
          acc     <= {32'd0, abs_b};
          operand <= abs_a;
        end else begin
          acc     <= {32'd0, abs_a};
          operand <= abs_b;
        end
      end else begin
        case (state)
          MULT: begin
            acc   <= mul_next;
            count <= count + 6'd1;
          end
          DIV: begin
            acc   <= div_next;
            count <= count + 6'd1;
          end
          DONE: begin
            data_resultRDY <= 1'b1;
            if (is_div) begin
              data_result    <= div_zero ? 32'd0 : quot;
              data_exception <= div_zero | div_ovf;
            end else begin
              data_result    <= prod[31:0];
              data_exception <= mul_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL have parameter ITER, default 32, meaning the number of iteration cycles per operation; only the value 32 is supported.
REQ-002 The block SHALL have port clock, input, 1 bit: master clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset; 0 clears all state immediately.
REQ-004 The block SHALL have port data_operandA, input, 32 bits: signed two's-complement operand A (multiplicand or dividend).
REQ-005 The block SHALL have port data_operandB, input, 32 bits: signed two's-complement operand B (multiplier or divisor).
REQ-006 The block SHALL have port ctrl_MULT, input, 1 bit: start-multiply request, sampled on the rising edge.
REQ-007 The block SHALL have port ctrl_DIV, input, 1 bit: start-divide request, sampled on the rising edge.
REQ-008 The block SHALL have port data_result, output, 32 bits: low 32 bits of the product, or the quotient.
REQ-009 The block SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero flag, valid with data_result.
REQ-010 The block SHALL have port data_resultRDY, output, 1 bit: one-cycle pulse marking data_result and data_exception valid.
REQ-011 The block SHALL have port busy, output, 1 bit: high while an operation is in progress; used by the execute stage to stall the pipeline.

Function
REQ-012 The FSM SHALL have states IDLE, MULT, DIV and DONE; it SHALL leave reset in IDLE.
REQ-013 The rising edge at which ctrl_MULT or ctrl_DIV is sampled high is the start edge (edge 0).
- Operands are captured at the start edge.
- The FSM enters MULT or DIV at the start edge.
- The iteration counter is cleared to 0 at the start edge.
REQ-014 If ctrl_MULT and ctrl_DIV are high together, MULT SHALL take precedence and DIV SHALL be ignored.
REQ-015 A start request arriving in any state, including mid-operation, SHALL abort the current operation and restart with the new operands.
- data_resultRDY SHALL NOT pulse for the aborted operation.
REQ-016 Iteration k SHALL occur at edge k (k = 1..32).
- The counter is 6 bits wide.
- The FSM enters DONE at edge 32.
REQ-017 At edge 33 the outputs SHALL be registered as follows:
- data_result and data_exception are loaded.
- data_resultRDY goes to 1.
- The FSM returns to IDLE.
REQ-018 data_resultRDY SHALL be 1 for exactly one cycle and SHALL return to 0 at edge 34.
REQ-019 data_result and data_exception SHALL hold their values until the next result is registered or reset occurs.
REQ-020 busy SHALL be 1 from the start edge through edge 33 exclusive, i.e. in states MULT, DIV and DONE.
REQ-021 Multiply SHALL use a radix-2 shift-add scheme with sign correction on a 64-bit accumulator.
- data_result = product[31:0].
- data_exception = 1 iff the signed 64-bit product lies outside [-2^31, 2^31-1], i.e. product[63:31] is not all-equal.
REQ-022 Divide SHALL use restoring division on operand magnitudes, one quotient bit per iteration.
- The quotient is truncated toward zero.
- The quotient is negated iff the operand signs differ.
- The remainder is discarded.
REQ-023 Divide by zero SHALL produce data_result = 0 and data_exception = 1, with the same 33-edge latency.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL produce data_result = 0x80000000 and data_exception = 1.
REQ-025 Operand input changes after the start edge SHALL NOT affect the operation in progress.
REQ-026 All arithmetic SHALL be 32-bit two's complement; no output shall ever be X after reset.

Reset
REQ-027 While reset = 0, regardless of clock:
- data_result = 0, data_exception = 0, data_resultRDY = 0 and busy = 0.
- The FSM is in IDLE and the counter is 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no data_resultRDY pulse follows release.
REQ-029 After reset is released, the first start edge SHALL behave exactly as in REQ-013.

Verification
REQ-030 MULT with A=7, B=-3 -> busy for 33 cycles, then at edge 33 data_result = 0xFFFFFFEB, exception = 0, data_resultRDY high for one cycle only.
REQ-031 MULT with A=0x00010000, B=0x00010000 -> data_result = 0x00000000, exception = 1; MULT with A=0x80000000, B=1 -> 0x80000000, exception = 0.
REQ-032 DIV with A=-7, B=2 -> data_result = 0xFFFFFFFD (-3), exception = 0; DIV with A=5, B=0 -> data_result = 0, exception = 1, latency 33 edges.
REQ-033 Start DIV with A=100, B=7, then at edge 10 start MULT with A=6, B=7 -> no pulse for the DIV; at edge 43 data_result = 42, data_resultRDY high.
REQ-034 Start MULT, pull reset low at edge 15 for 2 cycles, then release -> all outputs 0 immediately; no data_resultRDY for at least 40 cycles without a new start.
REQ-035 ctrl_MULT and ctrl_DIV high together with A=9, B=3 -> data_result = 27 (multiply), exception = 0.
